// File: rtl/osiris_pkg.sv
// Shared arbiter types: FSM state encodings, grant owner and the IDLE arbitration rule.
package osiris_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CORE = 2'd1,
    ARB_UART = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_CORE = 1'b0,
    GRANT_UART = 1'b1
  } grant_e;

  // Single requester wins; on contention the master that was not granted last wins.
  function automatic arb_state_e arb_pick(input logic core_req, input logic uart_req,
                                          input grant_e last);
    arb_state_e pick;
    pick = ARB_IDLE;
    if (core_req && uart_req) begin
      pick = (last == GRANT_UART) ? ARB_CORE : ARB_UART;
    end else if (core_req) begin
      pick = ARB_CORE;
    end else if (uart_req) begin
      pick = ARB_UART;
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Ack watchdog: counts stalled strobe cycles and flags when TIMEOUT is reached.
module arb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic tmo_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tmo_o = (cnt_q == CW'(TIMEOUT));

  // Clear wins over increment; the count saturates at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !tmo_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one Wishbone memory port between the core and the UART bridge
// with round-robin grant, cyc-locked bridge bursts and an ack watchdog.
module mem_port_arbiter
  import osiris_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic [ADDR_WIDTH-1:0] core_adr_i,
  input  logic [DATA_WIDTH-1:0] core_dat_i,
  output logic [DATA_WIDTH-1:0] core_dat_o,
  output logic                  core_ack_o,
  output logic                  core_stall_o,
  input  logic                  uart_cyc_i,
  input  logic                  uart_stb_i,
  input  logic                  uart_we_i,
  input  logic [ADDR_WIDTH-1:0] uart_adr_i,
  input  logic [DATA_WIDTH-1:0] uart_dat_i,
  output logic [DATA_WIDTH-1:0] uart_dat_o,
  output logic                  uart_ack_o,
  output logic                  mem_cyc_o,
  output logic                  mem_stb_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_adr_o,
  output logic [DATA_WIDTH-1:0] mem_dat_o,
  input  logic [DATA_WIDTH-1:0] mem_dat_i,
  input  logic                  mem_ack_i,
  output logic                  err_o
);

  arb_state_e            state_q;
  arb_state_e            state_d;
  arb_state_e            act_state;
  grant_e                last_grant_q;
  grant_e                last_grant_d;
  logic [DATA_WIDTH-1:0] core_dat_q;
  logic [DATA_WIDTH-1:0] core_dat_d;
  logic [DATA_WIDTH-1:0] uart_dat_q;
  logic [DATA_WIDTH-1:0] uart_dat_d;
  logic                  tmo_inc;
  logic                  tmo_clr;
  logic                  tmo;

  // A low rst kills the current grant immediately so no ack escapes.
  assign act_state = rst ? state_q : ARB_IDLE;

  arb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk  (clk),
    .rst  (rst),
    .clr_i(tmo_clr),
    .inc_i(tmo_inc),
    .tmo_o(tmo)
  );

  // Next state, grant bookkeeping and the output mux from the granted state.
  always_comb begin
    state_d      = act_state;
    last_grant_d = last_grant_q;
    core_dat_d   = core_dat_q;
    uart_dat_d   = uart_dat_q;
    tmo_inc      = 1'b0;
    mem_cyc_o    = 1'b0;
    mem_stb_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_adr_o    = '0;
    mem_dat_o    = '0;
    core_ack_o   = 1'b0;
    uart_ack_o   = 1'b0;
    err_o        = 1'b0;

    case (act_state)
      ARB_IDLE: begin
        state_d = arb_pick(core_req_i, uart_cyc_i & uart_stb_i, last_grant_q);
        if (state_d == ARB_CORE) begin
          last_grant_d = GRANT_CORE;
        end else if (state_d == ARB_UART) begin
          last_grant_d = GRANT_UART;
        end
      end

      ARB_CORE: begin
        mem_cyc_o = core_req_i;
        mem_stb_o = core_req_i;
        mem_we_o  = core_we_i;
        mem_adr_o = core_adr_i;
        mem_dat_o = core_dat_i;
        if (!core_req_i) begin
          state_d = ARB_IDLE;
        end else if (mem_ack_i) begin
          core_ack_o = 1'b1;
          core_dat_d = mem_dat_i;
          state_d    = ARB_IDLE;
        end else if (tmo) begin
          core_ack_o = 1'b1;
          err_o      = 1'b1;
          core_dat_d = '0;
          state_d    = ARB_IDLE;
        end else begin
          tmo_inc = 1'b1;
        end
      end

      ARB_UART: begin
        mem_cyc_o = uart_cyc_i;
        mem_stb_o = uart_stb_i;
        mem_we_o  = uart_we_i;
        mem_adr_o = uart_adr_i;
        mem_dat_o = uart_dat_i;
        // The bridge keeps the port for as long as it holds cyc.
        if (!uart_cyc_i) begin
          state_d = ARB_IDLE;
        end else if (mem_ack_i) begin
          uart_ack_o = 1'b1;
          uart_dat_d = mem_dat_i;
        end else if (uart_stb_i && tmo) begin
          uart_ack_o = 1'b1;
          err_o      = 1'b1;
          uart_dat_d = '0;
          state_d    = ARB_IDLE;
        end else if (uart_stb_i) begin
          tmo_inc = 1'b1;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    tmo_clr      = mem_ack_i || (state_d != act_state);
    core_dat_o   = rst ? core_dat_d : '0;
    uart_dat_o   = rst ? uart_dat_d : '0;
    core_stall_o = core_req_i & ~core_ack_o;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_UART;
      core_dat_q   <= '0;
      uart_dat_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      core_dat_q   <= core_dat_d;
      uart_dat_q   <= uart_dat_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed core/UART traffic against a
// registered-ack memory model; a negedge monitor pops expected responses on each ack.
module tb_mem_port_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 10;
  localparam int unsigned TMO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req_i, core_we_i;
  logic [AW-1:0] core_adr_i;
  logic [DW-1:0] core_dat_i, core_dat_o;
  logic          core_ack_o, core_stall_o;
  logic          uart_cyc_i, uart_stb_i, uart_we_i;
  logic [AW-1:0] uart_adr_i;
  logic [DW-1:0] uart_dat_i, uart_dat_o;
  logic          uart_ack_o;
  logic          mem_cyc_o, mem_stb_o, mem_we_o;
  logic [AW-1:0] mem_adr_o;
  logic [DW-1:0] mem_dat_o, mem_dat_i;
  logic          mem_ack_i;
  logic          err_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_adr_i(core_adr_i),
    .core_dat_i(core_dat_i), .core_dat_o(core_dat_o), .core_ack_o(core_ack_o),
    .core_stall_o(core_stall_o),
    .uart_cyc_i(uart_cyc_i), .uart_stb_i(uart_stb_i), .uart_we_i(uart_we_i),
    .uart_adr_i(uart_adr_i), .uart_dat_i(uart_dat_i), .uart_dat_o(uart_dat_o),
    .uart_ack_o(uart_ack_o),
    .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
    .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i),
    .mem_ack_i(mem_ack_i), .err_o(err_o)
  );

  // Memory model: registered single-cycle ack, no back-to-back acks, preset contents.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          preloaded = 1'b0;
  logic          mem_ack_en;
  logic          ack_q = 1'b0;
  logic [DW-1:0] rdata_q = '0;
  assign mem_ack_i = ack_q;
  assign mem_dat_i = rdata_q;

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int k = 0; k < (1 << AW); k++) mem[k] <= 32'h5A00_0000 | 32'(k);
      mem[4]    <= 32'hDEAD_BEEF;
      preloaded <= 1'b1;
      ack_q     <= 1'b0;
    end else if (!rst) begin
      ack_q <= 1'b0;
    end else if (mem_cyc_o && mem_stb_o && !ack_q && mem_ack_en) begin
      ack_q <= 1'b1;
      if (mem_we_o) begin
        mem[mem_adr_o] <= mem_dat_o;
        rdata_q        <= '0;
      end else begin
        rdata_q <= mem[mem_adr_o];
      end
    end else begin
      ack_q <= 1'b0;
    end
  end

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          err;
  } exp_t;

  exp_t  core_q[$];
  exp_t  uart_q[$];
  exp_t  mon_e;
  int    n_pass = 0;
  int    n_total = 0;
  int    cyc_cnt = 0;
  int    core_ack_cyc = 0;
  string order = "";

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
  endtask

  task automatic chk_fail(input string name);
    n_total++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  // Monitor: every ack pops one expectation; acks are also logged in grant order.
  always @(negedge clk) begin
    if (core_ack_o) begin
      if (core_q.size() == 0) chk_fail("core_unexpected_ack");
      else begin
        mon_e = core_q.pop_front();
        chk("core_dat", core_dat_o, mon_e.dat);
        chk("core_err", 32'(err_o), 32'(mon_e.err));
      end
      order = {order, "C"};
    end
    if (uart_ack_o) begin
      if (uart_q.size() == 0) chk_fail("uart_unexpected_ack");
      else begin
        mon_e = uart_q.pop_front();
        chk("uart_dat", uart_dat_o, mon_e.dat);
        chk("uart_err", 32'(err_o), 32'(mon_e.err));
      end
      order = {order, "U"};
    end
    if (err_o && !core_ack_o && !uart_ack_o) chk_fail("err_without_ack");
  end

  task automatic core_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input logic [DW-1:0] exp_dat, input logic exp_err, input int exp_lat);
    int lat;
    int stalls;
    core_q.push_back('{dat: exp_dat, err: exp_err});
    core_req_i = 1'b1; core_we_i = we; core_adr_i = adr; core_dat_i = dat;
    lat = 0; stalls = 0;
    while (lat < 200) begin
      @(negedge clk);
      if (core_ack_o) break;
      lat++;
      if (core_stall_o) stalls++;
    end
    if (lat >= 200) chk_fail("core_ack_timeout");
    core_ack_cyc = cyc_cnt;
    chk("core_stall_at_ack", 32'(core_stall_o), 32'd0);
    if (exp_lat >= 0) begin
      chk("core_latency", 32'(lat), 32'(exp_lat));
      chk("core_stall_cycles", 32'(stalls), 32'(exp_lat));
    end
    @(posedge clk); #1;
    core_req_i = 1'b0; core_we_i = 1'b0;
  endtask

  task automatic wait_uart_ack(input string name);
    int w;
    w = 0;
    while (w < 200) begin
      @(negedge clk);
      if (uart_ack_o) break;
      w++;
    end
    if (w >= 200) chk_fail(name);
  endtask

  task automatic uart_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input logic [DW-1:0] exp_dat);
    uart_q.push_back('{dat: exp_dat, err: 1'b0});
    uart_cyc_i = 1'b1; uart_stb_i = 1'b1; uart_we_i = we; uart_adr_i = adr; uart_dat_i = dat;
    wait_uart_ack("uart_ack_timeout");
    @(posedge clk); #1;
    uart_cyc_i = 1'b0; uart_stb_i = 1'b0; uart_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic uart_burst_wr(input logic [AW-1:0] base, input logic [DW-1:0] dbase);
    uart_cyc_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      uart_q.push_back('{dat: '0, err: 1'b0});
      uart_stb_i = 1'b1; uart_we_i = 1'b1;
      uart_adr_i = base + AW'(i); uart_dat_i = dbase + DW'(i);
      wait_uart_ack("uart_burst_ack_timeout");
      @(posedge clk); #1;
    end
    uart_cyc_i = 1'b0; uart_stb_i = 1'b0; uart_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; mem_ack_en = 1'b1;
    core_req_i = 1'b1; core_we_i = 1'b0; core_adr_i = '0; core_dat_i = '0;
    uart_cyc_i = 1'b0; uart_stb_i = 1'b0; uart_we_i = 1'b0; uart_adr_i = '0; uart_dat_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall_follows_req", 32'(core_stall_o), 32'd1);
    chk("rst_mem_cyc", 32'(mem_cyc_o), 32'd0);
    chk("rst_mem_stb", 32'(mem_stb_o), 32'd0);
    chk("rst_core_ack", 32'(core_ack_o), 32'd0);
    chk("rst_uart_ack", 32'(uart_ack_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_core_dat", core_dat_o, 32'd0);
    core_req_i = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    // Core-only reads, then a back-to-back read, then a bridge read.
    core_txn(1'b0, 10'h004, '0, 32'hDEAD_BEEF, 1'b0, 2);
    begin
      int first_ack;
      first_ack = core_ack_cyc;
      core_txn(1'b0, 10'h005, '0, 32'h5A00_0005, 1'b0, 2);
      chk("b2b_ack_spacing", 32'(core_ack_cyc - first_ack), 32'd3);
    end
    uart_txn(1'b0, 10'h007, '0, 32'h5A00_0007);
    chk("core_dat_hold", core_dat_o, 32'h5A00_0005);
    chk("uart_dat_hold", uart_dat_o, 32'h5A00_0007);

    // Both request straight after reset: core first.
    do_reset();
    order = "";
    fork
      core_txn(1'b0, 10'h004, '0, 32'hDEAD_BEEF, 1'b0, 2);
      uart_txn(1'b0, 10'h006, '0, 32'h5A00_0006);
    join
    chk_str("order_from_reset", order, "CU");

    // Continuous contention alternates grants.
    order = "";
    fork
      for (int i = 0; i < 3; i++)
        core_txn(1'b0, 10'h020 + AW'(i), '0, 32'h5A00_0020 + DW'(i), 1'b0, -1);
      for (int i = 0; i < 3; i++)
        uart_txn(1'b0, 10'h030 + AW'(i), '0, 32'h5A00_0030 + DW'(i));
    join
    chk_str("order_contention", order, "CUCUCU");

    // Locked bridge burst; pending core read of a freshly written word waits.
    order = "";
    fork
      uart_burst_wr(10'h010, 32'hA5A5_0010);
      begin
        repeat (2) @(posedge clk);
        #1;
        core_txn(1'b0, 10'h011, '0, 32'hA5A5_0011, 1'b0, -1);
      end
    join
    chk_str("order_burst_lock", order, "UUUUC");

    // Core watchdog: no mem ack -> err and zero data at grant + TIMEOUT.
    mem_ack_en = 1'b0;
    core_txn(1'b0, 10'h004, '0, 32'h0, 1'b1, 16);
    @(negedge clk);
    chk("tmo_core_idle", 32'(mem_cyc_o), 32'd0);

    // Bridge watchdog releases the lock although cyc stays high.
    uart_q.push_back('{dat: '0, err: 1'b1});
    uart_cyc_i = 1'b1; uart_stb_i = 1'b1; uart_we_i = 1'b0; uart_adr_i = 10'h008;
    wait_uart_ack("uart_tmo_ack_timeout");
    @(negedge clk);
    chk("tmo_uart_unlock", 32'(mem_cyc_o), 32'd0);
    @(posedge clk); #1;
    uart_cyc_i = 1'b0; uart_stb_i = 1'b0;
    @(posedge clk); #1;
    mem_ack_en = 1'b1;

    // Reset in the middle of a bridge grant drops it without an ack.
    uart_cyc_i = 1'b1; uart_stb_i = 1'b1; uart_adr_i = 10'h009;
    begin
      int w;
      w = 0;
      while (w < 20) begin
        @(negedge clk);
        if (mem_cyc_o) break;
        w++;
      end
      if (w >= 20) chk_fail("uart_grant_timeout");
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_mem_cyc", 32'(mem_cyc_o), 32'd0);
    chk("rstmid_mem_stb", 32'(mem_stb_o), 32'd0);
    chk("rstmid_mem_adr", 32'(mem_adr_o), 32'd0);
    chk("rstmid_uart_ack", 32'(uart_ack_o), 32'd0);
    uart_cyc_i = 1'b0; uart_stb_i = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    // Normal access after the reset.
    core_txn(1'b0, 10'h004, '0, 32'hDEAD_BEEF, 1'b0, 2);
    repeat (3) @(posedge clk);
    chk("core_q_drained", 32'(core_q.size()), 32'd0);
    chk("uart_q_drained", 32'(uart_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
